// File: rtl/dds_pkg.sv
// Shared sweep definitions: default widths and state encodings, also used by the command decoder.
// SWEEP_BIDIR_EN adds the descending-leg state STEP_DN.
package dds_pkg;

  localparam int W_DEF  = 32;
  localparam int DW_DEF = 24;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DWELL   = 3'd1;
  localparam logic [2:0] S_STEP    = 3'd2;
  localparam logic [2:0] S_END     = 3'd3;
`ifdef SWEEP_BIDIR_EN
  localparam logic [2:0] S_STEP_DN = 3'd4;
`endif

  // STEP/STEP_DN name the point-advance decision; the state register only rests in IDLE/DWELL/END.
  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_DWELL   = S_DWELL,
    ST_STEP    = S_STEP,
`ifdef SWEEP_BIDIR_EN
    ST_STEP_DN = S_STEP_DN,
`endif
    ST_END     = S_END
  } sweep_state_t;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Sweep configuration/control from the command decoder and the point stream toward the DDS.
// master drives config and requests; slave is the sweep controller.
interface dds_sweep_ctrl_if
  import dds_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int DW = DW_DEF
);
  logic [W-1:0]  start_word;
  logic [W-1:0]  stop_word;
  logic [W-1:0]  step_word;
  logic [DW-1:0] dwell;
  logic          repeat_en;
  logic          start;
  logic          abort;
  logic [W-1:0]  m;
  logic          set;
  logic          busy;
  logic          done;

  modport master (
    output start_word, stop_word, step_word, dwell, repeat_en, start, abort,
    input  m, set, busy, done
  );

  modport slave (
    input  start_word, stop_word, step_word, dwell, repeat_en, start, abort,
    output m, set, busy, done
  );
endinterface

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter for the per-point dwell; expire is high while the count sits at zero.
// A load takes priority over counting; the count stops at zero.
module dds_dwell_timer
  import dds_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] value,
  output logic          expire
);
  logic [DW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - DW'(1);
    end
  end

  assign expire = (cnt == '0);
endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency sweep: steps m from start to stop (clamped) with a fixed dwell per point, strobing set.
// SWEEP_BIDIR_EN: after the stop point the sweep descends back to start before done.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int DW = DW_DEF
) (
  input logic             clk,
  input logic             rst,
  dds_sweep_ctrl_if.slave bus
);
  sweep_state_t  state;
  sweep_state_t  next_op;
  logic [W-1:0]  start_l;
  logic [W-1:0]  stop_l;
  logic [W-1:0]  step_l;
  logic [DW-1:0] dwell_l;
  logic          rpt_l;
  logic [W-1:0]  m_r;
  logic          set_r;
  logic          busy_r;
  logic          done_r;

  logic          go;
  logic          adv;
  logic          load;
  logic          expire;
  logic [DW-1:0] dwell_src;
  logic [DW-1:0] load_val;
  logic [W:0]    sum;
  logic [W-1:0]  up_pt;
`ifdef SWEEP_BIDIR_EN
  logic          dn;
  logic [W:0]    diff;
  logic [W-1:0]  dn_pt;
`endif

  // Extra bit catches wrap-around so an overflowing step clamps to stop.
  assign sum   = {1'b0, m_r} + {1'b0, step_l};
  assign up_pt = (sum[W] || (sum[W-1:0] >= stop_l)) ? stop_l : sum[W-1:0];
`ifdef SWEEP_BIDIR_EN
  assign diff  = {1'b0, m_r} - {1'b0, step_l};
  assign dn_pt = (diff[W] || (diff[W-1:0] <= start_l)) ? start_l : diff[W-1:0];
`endif

  always_comb begin
    next_op = ST_END;
`ifdef SWEEP_BIDIR_EN
    if (!dn) begin
      if ((step_l != '0) && (m_r < stop_l)) begin
        next_op = ST_STEP;
      end else if ((step_l != '0) && (m_r > start_l)) begin
        next_op = ST_STEP_DN;
      end
    end else if (m_r > start_l) begin
      next_op = ST_STEP_DN;
    end
`else
    if ((step_l != '0) && (m_r < stop_l)) begin
      next_op = ST_STEP;
    end
`endif
  end

  // Timer is reloaded with max(dwell,1)-1 whenever a new point is presented.
  always_comb begin
    dwell_src = (state == ST_IDLE) ? bus.dwell : dwell_l;
    load_val  = (dwell_src == '0) ? '0 : dwell_src - DW'(1);
    go        = (state == ST_IDLE) && bus.start && !bus.abort;
    adv       = (state == ST_DWELL) && expire && !bus.abort &&
                ((next_op != ST_END) || rpt_l);
    load      = go || adv;
  end

  dds_dwell_timer #(.DW(DW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .value  (load_val),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      start_l <= '0;
      stop_l  <= '0;
      step_l  <= '0;
      dwell_l <= '0;
      rpt_l   <= 1'b0;
      m_r     <= '0;
      set_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef SWEEP_BIDIR_EN
      dn      <= 1'b0;
`endif
    end else begin
      set_r  <= 1'b0;
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) begin
            start_l <= bus.start_word;
            stop_l  <= bus.stop_word;
            step_l  <= bus.step_word;
            dwell_l <= bus.dwell;
            rpt_l   <= bus.repeat_en;
            m_r     <= bus.start_word;
            set_r   <= 1'b1;
            busy_r  <= 1'b1;
            state   <= ST_DWELL;
`ifdef SWEEP_BIDIR_EN
            dn      <= 1'b0;
`endif
          end
        end
        ST_DWELL: begin
          if (bus.abort) begin
            busy_r <= 1'b0;
            state  <= ST_IDLE;
          end else if (expire) begin
            case (next_op)
              ST_STEP: begin
                m_r   <= up_pt;
                set_r <= 1'b1;
              end
`ifdef SWEEP_BIDIR_EN
              ST_STEP_DN: begin
                m_r   <= dn_pt;
                set_r <= 1'b1;
                dn    <= 1'b1;
              end
`endif
              default: begin
                done_r <= 1'b1;
                if (rpt_l) begin
                  m_r   <= start_l;
                  set_r <= 1'b1;
`ifdef SWEEP_BIDIR_EN
                  dn    <= 1'b0;
`endif
                end else begin
                  busy_r <= 1'b0;
                  state  <= ST_END;
                end
              end
            endcase
          end
        end
        ST_END:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.m    = m_r;
  assign bus.set  = set_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl; expectations follow SWEEP_BIDIR_EN when defined.
module tb_dds_sweep_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   np;
  logic [31:0] pts [0:6];

  always #5 clk = ~clk;

  dds_sweep_ctrl_if #(.W(32), .DW(24)) bus ();

  dds_sweep_ctrl #(.W(32), .DW(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                     input logic [23:0] d, input logic r);
    bus.start_word = s;
    bus.stop_word  = e;
    bus.step_word  = st;
    bus.dwell      = d;
    bus.repeat_en  = r;
  endtask

  // Leaves the bench in cycle T+1 of the sweep.
  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    logic es;
    logic ed;
`ifdef SWEEP_BIDIR_EN
    np = 7;
    pts[0] = 100; pts[1] = 110; pts[2] = 120; pts[3] = 130;
    pts[4] = 120; pts[5] = 110; pts[6] = 100;
`else
    np = 4;
    pts[0] = 100; pts[1] = 110; pts[2] = 120; pts[3] = 130;
    pts[4] = 0;   pts[5] = 0;   pts[6] = 0;
`endif
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    cfg(32'd0, 32'd0, 32'd0, 24'd0, 1'b0);
    repeat (3) tick();
    check("rst_m", bus.m, 0);
    check("rst_set", bus.set, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    rst = 1'b0;
    tick();

    // Basic sweep; a start with junk config mid-sweep must be ignored.
    cfg(32'd100, 32'd130, 32'd10, 24'd4, 1'b0);
    pulse_start();
    for (int k = 1; k <= 4 * np + 1; k++) begin
      es = (k <= 4 * np) && ((k - 1) % 4 == 0);
      ed = (k == 4 * np + 1);
      check("sw_set", bus.set, es);
      check("sw_done", bus.done, ed);
      check("sw_busy", bus.busy, !ed);
      if (es) check("sw_m", bus.m, pts[(k - 1) / 4]);
      if (k == 6) begin
        bus.start = 1'b1;
        cfg(32'd7, 32'd8, 32'd1, 24'd1, 1'b1);
      end
      if (k == 7) bus.start = 1'b0;
      tick();
    end
    check("sw_after_done", bus.done, 0);
    check("sw_after_m", bus.m, pts[np - 1]);

    // Overflow clamp, dwell 0 treated as 1.
    cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 24'd0, 1'b0);
    pulse_start();
    check("cl_set1", bus.set, 1);
    check("cl_m1", bus.m, 32'hFFFF_FFF0);
    tick();
    check("cl_set2", bus.set, 1);
    check("cl_m2", bus.m, 32'hFFFF_FFFF);
    tick();
`ifdef SWEEP_BIDIR_EN
    check("cl_set3", bus.set, 1);
    check("cl_m3", bus.m, 32'hFFFF_FFF0);
    tick();
`endif
    check("cl_done", bus.done, 1);
    check("cl_busy", bus.busy, 0);
    check("cl_set_end", bus.set, 0);
    tick();
    check("cl_done_off", bus.done, 0);

    // Degenerate: start == stop.
    cfg(32'd50, 32'd50, 32'd10, 24'd3, 1'b0);
    pulse_start();
    check("dg_set", bus.set, 1);
    check("dg_m", bus.m, 50);
    tick();
    check("dg_hold_set", bus.set, 0);
    check("dg_hold_busy", bus.busy, 1);
    tick();
    tick();
    check("dg_done", bus.done, 1);
    check("dg_busy", bus.busy, 0);
    check("dg_m_end", bus.m, 50);
    tick();

    // Degenerate: step == 0.
    cfg(32'd50, 32'd200, 32'd0, 24'd2, 1'b0);
    pulse_start();
    check("dz_set", bus.set, 1);
    check("dz_m", bus.m, 50);
    tick();
    check("dz_hold_set", bus.set, 0);
    tick();
    check("dz_done", bus.done, 1);
    check("dz_m_end", bus.m, 50);
    tick();

    // Abort at the third point.
    cfg(32'd100, 32'd130, 32'd10, 24'd4, 1'b0);
    pulse_start();
    repeat (8) tick();
    check("ab_set_p3", bus.set, 1);
    check("ab_m_p3", bus.m, 120);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("ab_busy", bus.busy, 0);
    check("ab_set", bus.set, 0);
    check("ab_done", bus.done, 0);
    check("ab_m", bus.m, 120);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("ab_no_done", bus.done, 0);
      check("ab_no_set", bus.set, 0);
    end

    // Start and abort together from IDLE.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("sa_busy", bus.busy, 0);
    check("sa_set", bus.set, 0);
    tick();
    check("sa_busy2", bus.busy, 0);
    check("sa_m", bus.m, 120);

    // Reset in the middle of point 2.
    pulse_start();
    repeat (4) tick();
    check("rs_set_p2", bus.set, 1);
    check("rs_m_p2", bus.m, 110);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_m", bus.m, 0);
    check("rs_busy", bus.busy, 0);
    check("rs_set", bus.set, 0);
    check("rs_done", bus.done, 0);
    for (int k = 0; k < 14; k++) begin
      tick();
      check("rs_no_done", bus.done, 0);
    end

    // Automatic repeat.
    cfg(32'd100, 32'd130, 32'd10, 24'd4, 1'b1);
    pulse_start();
    repeat (4 * np) tick();
    check("rp_done", bus.done, 1);
    check("rp_set", bus.set, 1);
    check("rp_m", bus.m, 100);
    check("rp_busy", bus.busy, 1);
    repeat (4) tick();
    check("rp_set2", bus.set, 1);
    check("rp_m2", bus.m, 110);
    check("rp_done2", bus.done, 0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("rp_abort_busy", bus.busy, 0);
    check("rp_abort_set", bus.set, 0);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Frequency-sweep sequencer for the DDS core.
- Steps the 32-bit tuning word `m` from a start value to a stop value in fixed increments, holding each point for a programmable dwell.
- Pulses `set` once per new point.
- Sits between the UART command decoder (which supplies the sweep configuration registers) and the DDS phase accumulator (which consumes `m`/`set`).

Parameters:
- W, 32, tuning-word width.
- DW, 24, dwell counter width (cycles per point).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start_word  in  W  first tuning word.
- stop_word  in  W  last tuning word (inclusive).
- step_word  in  W  increment per point.
- dwell  in  DW  clk cycles per point; 0 treated as 1.
- repeat  in  1  1 = restart the sweep automatically after the end.
- start  in  1  1-cycle request to begin a sweep.
- abort  in  1  terminate the sweep.
- m  out  W  current tuning word to the DDS.
- set  out  1  1-cycle strobe: `m` holds a new point.
- busy  out  1  sweep in progress.
- done  out  1  1-cycle strobe at the end of each sweep.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, m=0, set=0, busy=0, done=0, dwell counter=0.
- States: IDLE, DWELL, STEP, END.
- IDLE:
  - On start=1 and abort=0, latch start/stop/step/dwell/repeat into internal registers.
  - Next cycle: m=start_word, set=1, busy=1, counter=max(dwell,1)-1, go to DWELL.
  - Config inputs are ignored after latching.
- DWELL:
  - Counter decrements each cycle.
  - At 0, go to STEP if more points remain, else END.
  - Each point is held exactly max(dwell,1) cycles, counting the set cycle.
- STEP:
  - Is a combinational decision, not an extra cycle.
  - Next point = m+step, computed in W+1 bits.
  - If the carry is set or the sum >= stop, next = stop (clamped).
  - The new value is loaded with set=1 on the cycle after the dwell of the previous point ends.
  - Hence consecutive set pulses are spaced exactly D cycles apart.
- Single-point sweep: start_word >= stop_word or step_word=0 gives only point start_word, then END.
- END:
  - done=1 for one cycle, coincident with busy=0.
  - m keeps the last point.
  - If the latched repeat=1: done=1 and, in the same cycle, m=latched start, set=1, busy stays 1, go to DWELL.
- abort=1 in any non-IDLE state: next cycle IDLE, busy=0, set=0, no done; m holds its value.
- abort and start in the same cycle: abort wins.
- start while busy: ignored.
- set and done are never asserted during reset.
- Example timeline (start at cycle T; start=100, stop=130, step=10, dwell=4): points 100/110/120/130, set at T+1, T+5, T+9, T+13; done at T+17.
- Non-divisible step (start=100, stop=125, step=10): points 100, 110, 120, 125.

Optional Feature:
- Macro: SWEEP_BIDIR_EN.
- Defined:
  - After the stop point, the sweep descends by step, clamped at start (borrow or value <= start gives start).
  - The stop point is not repeated.
  - done fires after the final start point.
  - Adds state STEP_DN.
  - Example: 100, 110, 120, 130, 120, 110, 100.
- Undefined: up-only sweep as above; STEP_DN is not present.

Decomposition:
- Package dds_pkg:
  - Localparams for state encoding (IDLE, DWELL, STEP, END, STEP_DN).
  - Default widths W=32, DW=24.
  - Shared with the command decoder for future sweep-register command codes.
- Sub-module: dds_dwell_timer.
  - Loadable down-counter: inputs load and value; output expire.
  - Instantiated once.
- Next-point add/clamp logic stays inline.

Test Plan:
- Reset mid-sweep: assert rst at point 2 -> next cycle m=0, busy=0, set=0; no done.
- Basic sweep: start=100, stop=130, step=10, dwell=4, start pulse at T -> set at T+1, T+5, T+9, T+13 with m=100, 110, 120, 130; done and busy=0 at T+17.
- Clamp/overflow: start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x20, dwell=0 -> points 0xFFFFFFF0, 0xFFFFFFFF, one cycle each; done at T+3.
- Degenerate: step=0 or start=stop=50 -> single set with m=50; done after the dwell.
- Control collisions: abort at point 3 -> IDLE next cycle, m=120 held, no done. A start pulse issued while busy has no effect. Start+abort in the same cycle from IDLE -> stays IDLE.
- Repeat (and SWEEP_BIDIR_EN):
  - repeat=1 -> done pulse and set with m=100 in the same cycle, busy stays high.
  - With the macro defined -> sequence 100, 110, 120, 130, 120, 110, 100, then done.
